// File: rtl/apb_chip_ctrl_arbiter.sv
// rtl/apb_chip_ctrl_arbiter.sv - round-robin arbiter sharing one chip-control APB master port
// One transfer in flight at a time; a watchdog aborts ACCESS phases that never see pready.
module apb_chip_ctrl_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             soc_clk_i,
  input  logic                             soc_rstn_synced_i,
  input  logic [N_REQ-1:0]                 req_psel_i,
  input  logic [N_REQ-1:0]                 req_penable_i,
  input  logic [N_REQ-1:0]                 req_pwrite_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      req_paddr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_pwdata_i,
  input  logic [N_REQ*(DATA_WIDTH/8)-1:0]  req_pstrb_i,
  input  logic [N_REQ*3-1:0]               req_pprot_i,
  output logic [N_REQ*DATA_WIDTH-1:0]      req_prdata_o,
  output logic [N_REQ-1:0]                 req_pready_o,
  output logic [N_REQ-1:0]                 req_pslverr_o,
  output logic [ADDR_WIDTH-1:0]            m_paddr_o,
  output logic [DATA_WIDTH-1:0]            m_pwdata_o,
  output logic [DATA_WIDTH/8-1:0]          m_pstrb_o,
  output logic [2:0]                       m_pprot_o,
  output logic                             m_pwrite_o,
  output logic                             m_psel_o,
  output logic                             m_penable_o,
  input  logic [DATA_WIDTH-1:0]            m_prdata_i,
  input  logic                             m_pready_i,
  input  logic                             m_pslverr_i,
  output logic                             timeout_o,
  output logic [$clog2(N_REQ)-1:0]         grant_id_o
);

  localparam int GID_W  = $clog2(N_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state, state_d;
  logic [GID_W-1:0]      ptr, gid, pick;
  logic                  found, load, capture, abort;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic                  timeout_q;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_strb;
  logic [2:0]            sel_prot;
  logic                  sel_write;
  int                    k;

  // Requester PENABLE carries no arbitration information; only PSEL is sampled.
  logic unused_penable;
  assign unused_penable = ^req_penable_i;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!found && req_psel_i[k]) begin
        found = 1'b1;
        pick  = GID_W'(k);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_prot  = '0;
    sel_write = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick == GID_W'(j)) begin
        sel_addr  = req_paddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_pwdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = req_pstrb_i[j*STRB_W +: STRB_W];
        sel_prot  = req_pprot_i[j*3 +: 3];
        sel_write = req_pwrite_i[j];
      end
    end
  end

  always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
    if (!soc_rstn_synced_i) state <= IDLE;
    else                    state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // A pready arriving on the last allowed cycle still wins over the abort.
        if (m_pready_i) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
    if (!soc_rstn_synced_i) begin
      ptr        <= GID_W'(N_REQ - 1);
      gid        <= '0;
      m_paddr_o  <= '0;
      m_pwdata_o <= '0;
      m_pstrb_o  <= '0;
      m_pprot_o  <= '0;
      m_pwrite_o <= 1'b0;
      cnt        <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (load) begin
        ptr        <= pick;
        gid        <= pick;
        m_paddr_o  <= sel_addr;
        m_pwdata_o <= sel_wdata;
        m_pstrb_o  <= sel_strb;
        m_pprot_o  <= sel_prot;
        m_pwrite_o <= sel_write;
      end
      if (state == ACCESS)    cnt <= cnt + 1'b1;
      else if (state == RESP) cnt <= '0;
      if (capture) begin
        resp_data <= m_prdata_i;
        resp_err  <= m_pslverr_i;
      end else if (abort) begin
        resp_data <= '0;
        resp_err  <= 1'b1;
      end
    end
  end

  assign m_psel_o    = (state == SETUP) || (state == ACCESS);
  assign m_penable_o = (state == ACCESS);
  assign timeout_o   = timeout_q;
  assign grant_id_o  = gid;

  always_comb begin
    req_pready_o  = '0;
    req_pslverr_o = '0;
    req_prdata_o  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (state == RESP && gid == GID_W'(j)) begin
        req_pready_o[j]                           = 1'b1;
        req_pslverr_o[j]                          = resp_err;
        req_prdata_o[j*DATA_WIDTH +: DATA_WIDTH] = resp_data;
      end
    end
  end

endmodule
